// File: rtl/tl_ul_pkg.sv
// TileLink-UL beat formats and opcode codes shared by the link buffer and its bench.
package tl_ul_pkg;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [4:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [4:0]  source;
    logic        sink;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } tl_d_t;

  localparam int TL_A_W = $bits(tl_a_t);
  localparam int TL_D_W = $bits(tl_d_t);

  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

endpackage

// File: rtl/tl_ul_fifo.sv
// Registered circular-buffer FIFO for one TileLink channel; no flow-through, full rate.
module tl_ul_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  // Ready depends only on stored state, so a full FIFO stays closed even while draining.
  assign in_ready  = (count != (PTR_W+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/tl_ul_link_buffer.sv
// TileLink-UL link stage: buffers A and D channels and tracks in-flight source IDs.
module tl_ul_link_buffer
  import tl_ul_pkg::*;
#(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2,
  parameter int SRC_W   = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              up_a_valid,
  output logic              up_a_ready,
  input  logic [TL_A_W-1:0] up_a_bits,
  output logic              dn_a_valid,
  input  logic              dn_a_ready,
  output logic [TL_A_W-1:0] dn_a_bits,
  input  logic              dn_d_valid,
  output logic              dn_d_ready,
  input  logic [TL_D_W-1:0] dn_d_bits,
  output logic              up_d_valid,
  input  logic              up_d_ready,
  output logic [TL_D_W-1:0] up_d_bits,
  output logic [SRC_W:0]    inflight_cnt,
  output logic              err_unexp_d
);

  localparam int NSRC = 2**SRC_W;

  tl_a_t            up_a;
  tl_a_t            dn_a;
  tl_d_t            dn_d;
  tl_d_t            up_d;
  logic [NSRC-1:0]  inflight;
  logic [NSRC-1:0]  inflight_nxt;
  logic [SRC_W-1:0] a_src;
  logic [SRC_W-1:0] dd_src;
  logic [SRC_W-1:0] ud_src;
  logic             a_busy;
  logic             a_fifo_ready;
  logic             a_fire;
  logic             dn_d_fire;
  logic             up_d_fire;
  logic             d_clr;

  assign up_a      = tl_a_t'(up_a_bits);
  assign dn_d      = tl_d_t'(dn_d_bits);
  assign dn_a_bits = dn_a;
  assign up_d_bits = up_d;

  assign a_src  = SRC_W'(up_a.source);
  assign dd_src = SRC_W'(dn_d.source);
  assign ud_src = SRC_W'(up_d.source);

  // The busy check uses the registered bitmap, so a same-cycle D release does not open A.
  assign a_busy     = inflight[a_src];
  assign up_a_ready = a_fifo_ready && !a_busy;
  assign a_fire     = up_a_valid && up_a_ready;
  assign dn_d_fire  = dn_d_valid && dn_d_ready;
  assign up_d_fire  = up_d_valid && up_d_ready;
  assign d_clr      = up_d_fire && inflight[ud_src];

  tl_ul_fifo #(.T(tl_a_t), .DEPTH(A_DEPTH)) u_a_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (up_a_valid && !a_busy),
    .in_ready  (a_fifo_ready),
    .in_data   (up_a),
    .out_valid (dn_a_valid),
    .out_ready (dn_a_ready),
    .out_data  (dn_a)
  );

  tl_ul_fifo #(.T(tl_d_t), .DEPTH(D_DEPTH)) u_d_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (dn_d_valid),
    .in_ready  (dn_d_ready),
    .in_data   (dn_d),
    .out_valid (up_d_valid),
    .out_ready (up_d_ready),
    .out_data  (up_d)
  );

  // A fire needs a clear bit and a clear needs a set bit, so one ID never sees both.
  always_comb begin
    inflight_nxt = inflight;
    if (d_clr)  inflight_nxt[ud_src] = 1'b0;
    if (a_fire) inflight_nxt[a_src]  = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight     <= '0;
      inflight_cnt <= '0;
      err_unexp_d  <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      case ({a_fire, d_clr})
        2'b10:   inflight_cnt <= inflight_cnt + (SRC_W+1)'(1);
        2'b01:   inflight_cnt <= inflight_cnt - (SRC_W+1)'(1);
        default: inflight_cnt <= inflight_cnt;
      endcase
      if (dn_d_fire && !inflight[dd_src]) err_unexp_d <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tl_ul_link_buffer.sv
// Scoreboard bench for tl_ul_link_buffer: directed scenarios plus randomized traffic.
module tb_tl_ul_link_buffer;
  import tl_ul_pkg::*;

  localparam int A_DEPTH = 2;
  localparam int D_DEPTH = 2;
  localparam int SRC_W   = 5;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           up_a_valid = 1'b0;
  logic           up_a_ready;
  tl_a_t          up_a_bits = '0;
  logic           dn_a_valid;
  logic           dn_a_ready = 1'b0;
  tl_a_t          dn_a_bits;
  logic           dn_d_valid = 1'b0;
  logic           dn_d_ready;
  tl_d_t          dn_d_bits = '0;
  logic           up_d_valid;
  logic           up_d_ready = 1'b0;
  tl_d_t          up_d_bits;
  logic [SRC_W:0] inflight_cnt;
  logic           err_unexp_d;

  tl_ul_link_buffer #(.A_DEPTH(A_DEPTH), .D_DEPTH(D_DEPTH), .SRC_W(SRC_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .up_a_valid   (up_a_valid),
    .up_a_ready   (up_a_ready),
    .up_a_bits    (up_a_bits),
    .dn_a_valid   (dn_a_valid),
    .dn_a_ready   (dn_a_ready),
    .dn_a_bits    (dn_a_bits),
    .dn_d_valid   (dn_d_valid),
    .dn_d_ready   (dn_d_ready),
    .dn_d_bits    (dn_d_bits),
    .up_d_valid   (up_d_valid),
    .up_d_ready   (up_d_ready),
    .up_d_bits    (up_d_bits),
    .inflight_cnt (inflight_cnt),
    .err_unexp_d  (err_unexp_d)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered queues for the two channels, a set of in-flight IDs, a sticky error.
  tl_a_t a_q[$];
  tl_d_t d_q[$];
  bit    m_infl[32];
  bit    m_err;
  int    dn_a_fires = 0;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_infl[i];
    return n;
  endfunction

  always @(negedge clock) begin
    bit a_f, da_f, dd_f, ud_f, pre_hit;
    if (!reset_n) begin
      chk("rst_dn_a_valid", dn_a_valid, 0);
      chk("rst_up_d_valid", up_d_valid, 0);
      chk("rst_inflight_cnt", inflight_cnt, 0);
      chk("rst_err", err_unexp_d, 0);
      chk("rst_up_a_ready", up_a_ready, 1);
      chk("rst_dn_d_ready", dn_d_ready, 1);
      a_q.delete();
      d_q.delete();
      foreach (m_infl[i]) m_infl[i] = 0;
      m_err = 0;
    end else begin
      chk("up_a_ready", up_a_ready, (a_q.size() < A_DEPTH) && !m_infl[up_a_bits.source]);
      chk("dn_d_ready", dn_d_ready, d_q.size() < D_DEPTH);
      chk("dn_a_valid", dn_a_valid, a_q.size() != 0);
      chk("up_d_valid", up_d_valid, d_q.size() != 0);
      if (dn_a_valid && a_q.size() != 0) chk("dn_a_bits", dn_a_bits, a_q[0]);
      if (up_d_valid && d_q.size() != 0) chk("up_d_bits", up_d_bits, d_q[0]);
      chk("inflight_cnt", inflight_cnt, m_count());
      chk("err_unexp_d", err_unexp_d, m_err);

      a_f  = up_a_valid && up_a_ready;
      da_f = dn_a_valid && dn_a_ready;
      dd_f = dn_d_valid && dn_d_ready;
      ud_f = up_d_valid && up_d_ready;
      if (da_f) begin
        dn_a_fires++;
        if (a_q.size() != 0) void'(a_q.pop_front());
      end
      if (a_f) a_q.push_back(up_a_bits);
      if (dd_f) begin
        if (!m_infl[dn_d_bits.source]) m_err = 1;
        d_q.push_back(dn_d_bits);
      end
      pre_hit = a_f ? m_infl[up_a_bits.source] : 1'b0;
      if (ud_f) begin
        m_infl[up_d_bits.source] = 0;
        if (d_q.size() != 0) void'(d_q.pop_front());
      end
      if (a_f && !pre_hit) m_infl[up_a_bits.source] = 1;
    end
  end

  function automatic tl_a_t make_a(input logic [2:0] op, input int src, input logic [31:0] addr,
                                   input logic [31:0] data);
    tl_a_t a;
    a = '0;
    a.opcode  = op;
    a.size    = 4'd2;
    a.source  = 5'(src);
    a.address = addr;
    a.mask    = 4'hf;
    a.data    = data;
    return a;
  endfunction

  function automatic tl_d_t make_d(input logic [2:0] op, input int src, input logic [31:0] data);
    tl_d_t d;
    d = '0;
    d.opcode = op;
    d.size   = 4'd2;
    d.source = 5'(src);
    d.data   = data;
    return d;
  endfunction

  task automatic send_a(input tl_a_t a);
    bit ok = 0;
    up_a_bits  = a;
    up_a_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (up_a_ready) begin ok = 1; break; end
    end
    @(posedge clock); #1;
    up_a_valid = 1'b0;
    chk("send_a_accepted", ok, 1);
  endtask

  task automatic send_d(input tl_d_t d);
    bit ok = 0;
    dn_d_bits  = d;
    dn_d_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (dn_d_ready) begin ok = 1; break; end
    end
    @(posedge clock); #1;
    dn_d_valid = 1'b0;
    chk("send_d_accepted", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!dn_a_valid && !up_d_valid) begin ok = 1; break; end
    end
    @(posedge clock); #1;
    chk("drain", ok, 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, start, seen;
    bit ok;
    tl_a_t held;

    // Reset state
    #2;
    chk("reset_up_a_ready", up_a_ready, 1);
    chk("reset_dn_d_ready", dn_d_ready, 1);
    chk("reset_dn_a_valid", dn_a_valid, 0);
    chk("reset_cnt", inflight_cnt, 0);
    cycles(3);
    reset_n = 1'b1;

    // 1: single Get, one-cycle latency to dn A
    dn_a_ready = 1'b1;
    up_d_ready = 1'b1;
    send_a(make_a(OP_GET, 3, 32'h8000_0000, 32'h0));
    chk("t1_dn_a_valid", dn_a_valid, 1);
    chk("t1_dn_a_src", dn_a_bits.source, 3);
    chk("t1_cnt", inflight_cnt, 1);
    cycles(1);

    // 2: two Puts into a stalled slave
    dn_a_ready = 1'b0;
    send_a(make_a(OP_PUT_FULL, 1, 32'h100, 32'hdead_beef));
    held = dn_a_bits;
    send_a(make_a(OP_PUT_PARTIAL, 2, 32'h104, 32'h1234_5678));
    up_a_bits = make_a(OP_GET, 9, 32'h0, 32'h0);
    #1;
    chk("t2_full_ready", up_a_ready, 0);
    cycles(3);
    chk("t2_head_stable", dn_a_bits, held);
    dn_a_ready = 1'b1;
    @(negedge clock);
    chk("t2_beat0_src", dn_a_valid ? 32'(dn_a_bits.source) : 32'hff, 1);
    @(negedge clock);
    chk("t2_beat1_src", dn_a_valid ? 32'(dn_a_bits.source) : 32'hff, 2);
    @(negedge clock);
    chk("t2_empty", dn_a_valid, 0);
    @(posedge clock); #1;
    send_d(make_d(OP_ACCESS_ACK_DATA, 3, 32'h55));
    send_d(make_d(OP_ACCESS_ACK, 1, 32'h0));
    send_d(make_d(OP_ACCESS_ACK, 2, 32'h0));
    wait_idle();
    chk("t2_cnt_zero", inflight_cnt, 0);

    // 3: reissue of an ID held off until its ack leaves on up D
    send_a(make_a(OP_GET, 7, 32'h200, 32'h0));
    up_a_bits  = make_a(OP_GET, 7, 32'h204, 32'h0);
    up_a_valid = 1'b1;
    cycles(2);
    chk("t3_blocked", up_a_ready, 0);
    send_d(make_d(OP_ACCESS_ACK_DATA, 7, 32'h77));
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (up_d_valid && up_d_ready && up_d_bits.source == 7) begin
        chk("t3_same_cycle_ready", up_a_ready, 0);
        @(negedge clock);
        chk("t3_next_cycle_ready", up_a_ready, 1);
        seen = 1;
        break;
      end
    end
    chk("t3_ack_seen", seen, 1);
    @(posedge clock); #1;
    up_a_valid = 1'b0;
    send_d(make_d(OP_ACCESS_ACK_DATA, 7, 32'h78));
    wait_idle();

    // 4: unexpected D
    chk("t4_err_before", err_unexp_d, 0);
    send_d(make_d(OP_ACCESS_ACK, 12, 32'h0));
    chk("t4_err_set", err_unexp_d, 1);
    chk("t4_forwarded", up_d_valid, 1);
    wait_idle();
    cycles(3);
    chk("t4_err_sticky", err_unexp_d, 1);
    chk("t4_cnt", inflight_cnt, 0);

    // 5: 32 back-to-back Gets with distinct IDs
    acc   = 0;
    start = dn_a_fires;
    up_a_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      up_a_bits = make_a(OP_GET, i, 32'h1000 + 32'(i * 4), 32'h0);
      @(negedge clock);
      if (up_a_ready) acc++;
      @(posedge clock); #1;
    end
    up_a_valid = 1'b0;
    cycles(2);
    chk("t5_accepted", acc, 32);
    chk("t5_dn_a_beats", dn_a_fires - start, 32);
    chk("t5_cnt", inflight_cnt, 32);
    for (int i = 0; i < 32; i++) send_d(make_d(OP_ACCESS_ACK_DATA, i, 32'(i)));
    wait_idle();
    chk("t5_cnt_zero", inflight_cnt, 0);

    // 6: asynchronous reset with both FIFOs full
    dn_a_ready = 1'b0;
    up_d_ready = 1'b0;
    send_a(make_a(OP_GET, 4, 32'h300, 32'h0));
    send_a(make_a(OP_GET, 5, 32'h304, 32'h0));
    send_d(make_d(OP_ACCESS_ACK, 20, 32'h0));
    send_d(make_d(OP_ACCESS_ACK, 21, 32'h0));
    chk("t6_a_full", up_a_ready, 0);
    chk("t6_d_full", dn_d_ready, 0);
    chk("t6_up_d_valid", up_d_valid, 1);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_dn_a_valid", dn_a_valid, 0);
    chk("t6_async_up_d_valid", up_d_valid, 0);
    chk("t6_async_cnt", inflight_cnt, 0);
    chk("t6_async_err", err_unexp_d, 0);
    cycles(2);
    reset_n = 1'b1;
    dn_a_ready = 1'b1;
    up_d_ready = 1'b1;
    @(negedge clock);
    chk("t6_no_replay", dn_a_valid, 0);
    @(posedge clock); #1;

    // Randomized traffic over a small ID pool so reissue collisions are frequent
    for (int c = 0; c < 3000; c++) begin
      int src;
      up_a_valid = ($urandom_range(0, 2) != 0);
      up_a_bits  = make_a((($urandom_range(0, 2) == 0) ? OP_GET :
                           (($urandom_range(0, 1) == 0) ? OP_PUT_FULL : OP_PUT_PARTIAL)),
                          $urandom_range(0, 7), $urandom(), $urandom());
      up_a_bits.mask = 4'($urandom_range(0, 15));
      dn_a_ready = ($urandom_range(0, 3) != 0);
      up_d_ready = ($urandom_range(0, 3) != 0);
      src = $urandom_range(0, 7);
      if ($urandom_range(0, 9) != 0) begin
        for (int k = 0; k < 8; k++) if (m_infl[(src + k) % 8]) begin src = (src + k) % 8; break; end
      end
      dn_d_valid = ($urandom_range(0, 1) != 0);
      dn_d_bits  = make_d(($urandom_range(0, 1) != 0) ? OP_ACCESS_ACK : OP_ACCESS_ACK_DATA,
                          src, $urandom());
      dn_d_bits.denied = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    up_a_valid = 1'b0;
    dn_d_valid = 1'b0;
    dn_a_ready = 1'b1;
    up_d_ready = 1'b1;
    wait_idle();
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
